// File: rtl/bus_xfer_ctrl.sv
// Initiator for the shared register bus. It sequences one command through
// DRIVE, STROBE and DONE, and issues one-hot ld/inc/clr strobes at dst.
module bus_xfer_ctrl #(
    parameter int NREG = 8,
    parameter int IW   = 4,
    parameter int DW   = 16
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [IW-1:0]   cmd_src,
    input  logic [IW-1:0]   cmd_dst,
    input  logic [DW-1:0]   cmd_imm,
    output logic [IW-1:0]   bus_sel,
    output logic            bus_imm_en,
    output logic [DW-1:0]   imm_out,
    input  logic [DW-1:0]   bus_in,
    output logic [NREG-1:0] reg_ld,
    output logic [NREG-1:0] reg_inc,
    output logic [NREG-1:0] reg_clr,
    output logic [DW-1:0]   rd_data,
    output logic            done,
    output logic            err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_STROBE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [1:0] OP_MOVE = 2'd0;
    localparam logic [1:0] OP_LDI  = 2'd1;
    localparam logic [1:0] OP_INC  = 2'd2;
    localparam logic [1:0] OP_CLR  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [IW-1:0] dst_q, dst_d;
    logic          bad_q, bad_d;
    logic [IW-1:0] bus_sel_q, bus_sel_d;
    logic          bus_imm_en_q, bus_imm_en_d;
    logic [DW-1:0] imm_out_q, imm_out_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          cmd_bad;

    // Decided once at acceptance; an illegal command still walks the FSM.
    assign cmd_bad = (int'(cmd_dst) >= NREG) ||
                     ((cmd_op == OP_MOVE) && (int'(cmd_src) >= NREG));

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        dst_d        = dst_q;
        bad_d        = bad_q;
        bus_sel_d    = bus_sel_q;
        bus_imm_en_d = bus_imm_en_q;
        imm_out_d    = imm_out_q;
        rd_data_d    = rd_data_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_DRIVE;
                    op_d    = cmd_op;
                    dst_d   = cmd_dst;
                    bad_d   = cmd_bad;
                    // Bus outputs are registered here so they are valid throughout DRIVE.
                    if (cmd_op == OP_MOVE) begin
                        bus_sel_d    = cmd_src;
                        bus_imm_en_d = 1'b0;
                    end else if (cmd_op == OP_LDI) begin
                        bus_imm_en_d = 1'b1;
                        imm_out_d    = cmd_imm;
                    end
                end
            end
            S_DRIVE: state_d = S_STROBE;
            S_STROBE: begin
                state_d      = S_DONE;
                bus_imm_en_d = 1'b0;
                if (!bad_q && (op_q == OP_MOVE || op_q == OP_LDI))
                    rd_data_d = bus_in;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        reg_ld  = '0;
        reg_inc = '0;
        reg_clr = '0;
        if (state_q == S_STROBE && !bad_q) begin
            for (int i = 0; i < NREG; i++) begin
                if (dst_q == IW'(i)) begin
                    case (op_q)
                        OP_INC:  reg_inc[i] = 1'b1;
                        OP_CLR:  reg_clr[i] = 1'b1;
                        default: reg_ld[i]  = 1'b1;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= S_IDLE;
            op_q         <= OP_MOVE;
            dst_q        <= '0;
            bad_q        <= 1'b0;
            bus_sel_q    <= '0;
            bus_imm_en_q <= 1'b0;
            imm_out_q    <= '0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            dst_q        <= dst_d;
            bad_q        <= bad_d;
            bus_sel_q    <= bus_sel_d;
            bus_imm_en_q <= bus_imm_en_d;
            imm_out_q    <= imm_out_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_DONE) && bad_q;
    assign bus_sel    = bus_sel_q;
    assign bus_imm_en = bus_imm_en_q;
    assign imm_out    = imm_out_q;
    assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: register bank on the bus, command-level reference
// model, directed scenarios and a randomized command stream.
module tb_bus_xfer_ctrl;

    localparam int NREG = 8;
    localparam int IW   = 4;
    localparam int DW   = 16;

    logic            clk = 1'b0;
    logic            clr;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [IW-1:0]   cmd_src;
    logic [IW-1:0]   cmd_dst;
    logic [DW-1:0]   cmd_imm;
    logic [IW-1:0]   bus_sel;
    logic            bus_imm_en;
    logic [DW-1:0]   imm_out;
    logic [DW-1:0]   bus_in;
    logic [NREG-1:0] reg_ld;
    logic [NREG-1:0] reg_inc;
    logic [NREG-1:0] reg_clr;
    logic [DW-1:0]   rd_data;
    logic            done;
    logic            err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bus_xfer_ctrl #(.NREG(NREG), .IW(IW), .DW(DW)) dut (
        .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
        .bus_sel(bus_sel), .bus_imm_en(bus_imm_en), .imm_out(imm_out), .bus_in(bus_in),
        .reg_ld(reg_ld), .reg_inc(reg_inc), .reg_clr(reg_clr), .rd_data(rd_data),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register bank sitting on the bus (clr > ld > inc).
    logic [DW-1:0] rf [NREG];
    logic          rf_init;
    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rf_init)         rf[i] <= '0;
            else if (reg_clr[i]) rf[i] <= '0;
            else if (reg_ld[i])  rf[i] <= bus_in;
            else if (reg_inc[i]) rf[i] <= rf[i] + 16'd1;
        end
    end
    always_comb bus_in = bus_imm_en ? imm_out :
                         ((int'(bus_sel) < NREG) ? rf[bus_sel[2:0]] : 16'hDEAD);

    // Command-level reference model.
    logic [DW-1:0] m_rf [NREG];
    logic [DW-1:0] m_rd;

    function automatic bit model_bad(input int op, input int src, input int dst);
        return (dst >= NREG) || (op == 0 && src >= NREG);
    endfunction

    task automatic model_apply(input int op, input int src, input int dst, input logic [DW-1:0] imm);
        if (model_bad(op, src, dst)) return;
        case (op)
            0: begin m_rf[dst] = m_rf[src]; m_rd = m_rf[src]; end
            1: begin m_rf[dst] = imm; m_rd = imm; end
            2: m_rf[dst] = m_rf[dst] + 16'd1;
            default: m_rf[dst] = '0;
        endcase
    endtask

    // Observations of one command: index 0 DRIVE, 1 STROBE, 2 DONE, 3 IDLE.
    logic [NREG-1:0] o_ld [4];
    logic [NREG-1:0] o_inc [4];
    logic [NREG-1:0] o_clr [4];
    logic [3:0]      o_done, o_err, o_rdy;
    logic [IW-1:0]   o_sel;
    logic            o_immen;
    logic [DW-1:0]   o_imm;
    bit              o_acc;
    int              o_done_cyc;

    task automatic run_cmd(input int op, input int src, input int dst, input logic [DW-1:0] imm);
        int n = 0;
        cmd_op = op[1:0]; cmd_src = src[IW-1:0]; cmd_dst = dst[IW-1:0]; cmd_imm = imm;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        o_acc = cmd_ready;
        if (!o_acc) begin cmd_valid = 1'b0; return; end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            o_ld[k] = reg_ld; o_inc[k] = reg_inc; o_clr[k] = reg_clr;
            o_done[k] = done; o_err[k] = err; o_rdy[k] = cmd_ready;
            if (k == 0) begin o_sel = bus_sel; o_immen = bus_imm_en; o_imm = imm_out; end
            if (k == 2) o_done_cyc = cyc;
        end
    endtask

    task automatic test_reset;
        clr = 1'b1; rf_init = 1'b1; cmd_valid = 1'b0;
        cmd_op = '0; cmd_src = '0; cmd_dst = '0; cmd_imm = '0;
        repeat (3) @(negedge clk);
        clr = 1'b0; rf_init = 1'b0;
        for (int i = 0; i < NREG; i++) m_rf[i] = '0;
        m_rd = '0;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        n_checks++; if ({done, err} !== 2'b00) begin n_fail++; $display("FAIL reset_done_err: got %b want 00", {done, err}); end
        n_checks++; if ((reg_ld | reg_inc | reg_clr) !== '0) begin n_fail++; $display("FAIL reset_strobes: got %b/%b/%b want 0", reg_ld, reg_inc, reg_clr); end
        n_checks++; if ({bus_sel, bus_imm_en, imm_out, rd_data} !== '0) begin n_fail++;
            $display("FAIL reset_bus: sel %h en %b imm %h rd %h want all 0", bus_sel, bus_imm_en, imm_out, rd_data); end
    endtask

    task automatic test_load_imm;
        model_apply(1, 0, 3, 16'hA5A5);
        run_cmd(1, 0, 3, 16'hA5A5);
        n_checks++; if (!o_acc) begin n_fail++; $display("FAIL ldi_accept: got 0 want 1"); end
        n_checks++; if (o_ld[1] !== 8'b00001000) begin n_fail++; $display("FAIL ldi_strobe: got %b want 00001000", o_ld[1]); end
        n_checks++; if ((o_ld[0] | o_ld[2] | o_ld[3]) !== '0) begin n_fail++; $display("FAIL ldi_strobe_width: got %b want 0", o_ld[0] | o_ld[2] | o_ld[3]); end
        n_checks++; if ({o_immen, o_imm} !== {1'b1, 16'hA5A5}) begin n_fail++; $display("FAIL ldi_drive: got en %b imm %h want 1 a5a5", o_immen, o_imm); end
        n_checks++; if (o_done !== 4'b0100) begin n_fail++; $display("FAIL ldi_done: got %b want 0100", o_done); end
        n_checks++; if (o_rdy !== 4'b1000) begin n_fail++; $display("FAIL ldi_ready: got %b want 1000", o_rdy); end
        n_checks++; if (rd_data !== 16'hA5A5) begin n_fail++; $display("FAIL ldi_rd: got %h want a5a5", rd_data); end
        n_checks++; if (rf[3] !== m_rf[3]) begin n_fail++; $display("FAIL ldi_reg: got %h want %h", rf[3], m_rf[3]); end
    endtask

    task automatic test_move;
        model_apply(1, 0, 3, 16'h1234);
        run_cmd(1, 0, 3, 16'h1234);
        model_apply(0, 3, 5, '0);
        run_cmd(0, 3, 5, '0);
        n_checks++; if ({o_sel, o_immen} !== {4'd3, 1'b0}) begin n_fail++; $display("FAIL move_drive: got sel %0d en %b want 3 0", o_sel, o_immen); end
        n_checks++; if (o_ld[1] !== 8'b00100000) begin n_fail++; $display("FAIL move_strobe: got %b want 00100000", o_ld[1]); end
        n_checks++; if (rf[5] !== 16'h1234 || m_rf[5] !== 16'h1234) begin n_fail++; $display("FAIL move_reg: got %h want 1234", rf[5]); end
        n_checks++; if (rd_data !== 16'h1234) begin n_fail++; $display("FAIL move_rd: got %h want 1234", rd_data); end
    endtask

    task automatic test_inc_clear;
        int t0;
        model_apply(1, 0, 0, 16'hFFFF);
        run_cmd(1, 0, 0, 16'hFFFF);
        model_apply(2, 0, 0, '0);
        run_cmd(2, 0, 0, '0);
        t0 = o_done_cyc;
        n_checks++; if (o_inc[1] !== 8'b00000001 || o_ld[1] !== '0) begin n_fail++; $display("FAIL inc_strobe: got inc %b ld %b want 00000001 0", o_inc[1], o_ld[1]); end
        n_checks++; if (rf[0] !== 16'h0000) begin n_fail++; $display("FAIL inc_wrap: got %h want 0000", rf[0]); end
        model_apply(3, 0, 0, '0);
        run_cmd(3, 0, 0, '0);
        n_checks++; if (o_clr[1] !== 8'b00000001 || o_inc[1] !== '0) begin n_fail++; $display("FAIL clr_strobe: got clr %b inc %b want 00000001 0", o_clr[1], o_inc[1]); end
        n_checks++; if (o_done_cyc - t0 !== 4) begin n_fail++; $display("FAIL done_spacing: got %0d want 4", o_done_cyc - t0); end
    endtask

    task automatic test_illegal;
        logic [DW-1:0] rd0, r2;
        rd0 = m_rd; r2 = m_rf[2];
        model_apply(0, 9, 2, '0);
        run_cmd(0, 9, 2, '0);
        n_checks++; if ((o_ld[0] | o_ld[1] | o_ld[2] | o_ld[3] | o_inc[1] | o_clr[1]) !== '0) begin n_fail++;
            $display("FAIL illegal_strobes: got ld %b want 0", o_ld[1]); end
        n_checks++; if ({o_done, o_err} !== {4'b0100, 4'b0100}) begin n_fail++; $display("FAIL illegal_err: got done %b err %b want 0100 0100", o_done, o_err); end
        n_checks++; if (rd_data !== rd0) begin n_fail++; $display("FAIL illegal_rd: got %h want %h", rd_data, rd0); end
        n_checks++; if (rf[2] !== r2) begin n_fail++; $display("FAIL illegal_reg: got %h want %h", rf[2], r2); end
    endtask

    task automatic test_back_to_back;
        int acc[$];
        logic [DW-1:0] r1;
        r1 = m_rf[1];
        cmd_op = 2'd2; cmd_dst = 4'd1; cmd_src = '0; cmd_valid = 1'b1;
        for (int n = 0; n < 40 && acc.size() < 3; n++) begin
            if (cmd_ready) acc.push_back(cyc);
            if (acc.size() == 3) begin @(posedge clk); #1 cmd_valid = 1'b0; end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) model_apply(2, 0, 1, '0);
        n_checks++; if (acc.size() !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", acc.size()); end
        else begin
            n_checks++; if (acc[1] - acc[0] !== 4 || acc[2] - acc[1] !== 4) begin n_fail++;
                $display("FAIL b2b_spacing: got %0d %0d want 4 4", acc[1] - acc[0], acc[2] - acc[1]); end
        end
        n_checks++; if (rf[1] !== r1 + 16'd3 || rf[1] !== m_rf[1]) begin n_fail++; $display("FAIL b2b_reg: got %h want %h", rf[1], r1 + 16'd3); end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        cmd_op = 2'd1; cmd_dst = 4'd4; cmd_src = '0; cmd_imm = 16'hBEEF; cmd_valid = 1'b1;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (reg_ld !== 8'b00010000) begin n_fail++; $display("FAIL mid_strobe: got %b want 00010000", reg_ld); end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_rf[4] = 16'hBEEF; m_rd = '0;
        n_checks++; if ((reg_ld | reg_inc | reg_clr) !== '0) begin n_fail++; $display("FAIL mid_strobes_off: got %b want 0", reg_ld); end
        n_checks++; if ({cmd_ready, done, err} !== 3'b100) begin n_fail++; $display("FAIL mid_ctrl: got rdy/done/err %b want 100", {cmd_ready, done, err}); end
        n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL mid_rd: got %h want 0000", rd_data); end
        @(negedge clk);
        n_checks++; if (reg_ld !== '0 || rf[4] !== m_rf[4]) begin n_fail++; $display("FAIL mid_after: ld %b reg %h want 0 beef", reg_ld, rf[4]); end
    endtask

    task automatic test_random;
        for (int t = 0; t < 60; t++) begin
            int op, src, dst;
            logic [DW-1:0] imm;
            logic [NREG-1:0] e;
            bit bad, mismatch;
            op = $urandom_range(0, 3); src = $urandom_range(0, 9); dst = $urandom_range(0, 9);
            imm = DW'($urandom);
            bad = model_bad(op, src, dst);
            e = bad ? '0 : (NREG'(1) << dst);
            model_apply(op, src, dst, imm);
            run_cmd(op, src, dst, imm);
            n_checks++; if (!o_acc) begin n_fail++; $display("FAIL rnd_accept[%0d]: got 0 want 1", t); end
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (o_ld[k] !== ((k == 1 && op < 2) ? e : '0) || o_inc[k] !== ((k == 1 && op == 2) ? e : '0) ||
                    o_clr[k] !== ((k == 1 && op == 3) ? e : '0)) begin
                    n_fail++; $display("FAIL rnd_strobe[%0d/%0d]: op %0d dst %0d got %b/%b/%b want %b", t, k, op, dst, o_ld[k], o_inc[k], o_clr[k], (k == 1) ? e : '0);
                end
            end
            n_checks++; if ({o_done, o_err} !== {4'b0100, bad ? 4'b0100 : 4'b0000}) begin n_fail++;
                $display("FAIL rnd_done_err[%0d]: got %b %b want 0100 bad=%0d", t, o_done, o_err, bad); end
            n_checks++; if (rd_data !== m_rd) begin n_fail++; $display("FAIL rnd_rd[%0d]: got %h want %h", t, rd_data, m_rd); end
            mismatch = 1'b0;
            for (int i = 0; i < NREG; i++) if (rf[i] !== m_rf[i]) mismatch = 1'b1;
            n_checks++; if (mismatch) begin n_fail++; $display("FAIL rnd_regs[%0d]: R%0d got %h want %h", t, dst % NREG, rf[dst % NREG], m_rf[dst % NREG]); end
        end
    endtask

    initial begin
        clr = 1'b1; rf_init = 1'b1; cmd_valid = 1'b0;
        @(negedge clk);
        test_reset;
        test_load_imm;
        test_move;
        test_inc_clear;
        test_illegal;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
